keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  4x4 matrix keypad scanner and debouncer. Produces the key codes the clock's time-set logic consumes.
//  Drives one column low at a time, samples the rows and debounces over whole scan frames.
//  Emits exactly one single-cycle key_valid per debounced press, with a 4-bit key_code.
//  Sits between the board keypad pins and the watch/time-set logic, in the same 1 kHz clock domain.
// PARAMETERS
//  COL_TICKS        4   clk cycles each column is driven; rows sampled on the last cycle (settling)
//  DEBOUNCE_FRAMES  3   consecutive identical frame results required for press and for release
// PORTS
//  clk           in   1  system clock (1 kHz); single clock domain
//  rst           in   1  reset, synchronous, active-high
//  key_row       in   4  row lines, active-low (pulled up); asynchronous to clk
//  key_col       out  4  column drive, active-low one-hot
//  key_code      out  4  code of last debounced key; held until next press
//  key_valid     out  1  one-cycle pulse: new debounced press, key_code valid same cycle
//  key_held      out  1  high from press acceptance until release is debounced
//  key_is_digit  out  1  key_code <= 9; registered together with key_code
// BEHAVIOUR
//  Reset: all state is cleared on the first rising clk edge with rst=1.
//   - key_col=4'b1110, key_code=0, key_valid=0, key_held=0, key_is_digit=0.
//   - FSM=IDLE; column index=0; tick and frame counters=0; synchronizer flops=4'b1111.
//  Sync: key_row passes through a 2-flop synchronizer. Sampling uses the synchronized value.
//  Scan: col_idx 0..3 advances every COL_TICKS cycles and wraps 3->0. Frame = 4*COL_TICKS cycles.
//   - On the last tick of a column: hits = ~row_sync. Count hits across the frame.
//  Frame result, evaluated at the frame end (last tick of col 3):
//   - NONE: 0 hits.
//   - SINGLE(code): exactly 1 hit.
//   - MULTI: 2 or more hits.
//  Key map [row][col]: r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: E 0 F D (A=10 .. F=15).
//  FSM. All transitions happen only at frame end.
//   - IDLE: SINGLE(c) -> cand=c, cnt=1, DEBOUNCE. NONE or MULTI -> stay.
//   - DEBOUNCE: SINGLE(cand) -> cnt++.
//       On reaching DEBOUNCE_FRAMES: key_code=cand, key_valid=1 for one cycle, key_held=1, state HELD.
//     SINGLE(other) -> cand=other, cnt=1.
//     NONE or MULTI -> IDLE.
//   - HELD: NONE -> rel_cnt++. Anything else -> rel_cnt=0.
//     rel_cnt==DEBOUNCE_FRAMES -> key_held=0, rel_cnt=0, IDLE.
//  No auto-repeat: one pulse per press. A release glitch shorter than DEBOUNCE_FRAMES gives no new pulse.
//  Latency: first stable frame -> key_valid asserts at the end of frame DEBOUNCE_FRAMES (+2 sync cycles).
//  Multi-key: a frame with 2+ hits never produces a press. Releasing down to one key starts a new debounce.
//  rst mid-operation: any pending debounce is dropped and no key_valid is emitted. The scan restarts at col 0.
//  Counter widths: tick ceil(log2 COL_TICKS); cnt and rel_cnt ceil(log2(DEBOUNCE_FRAMES+1)). No overflow.
// STRUCTURE
//  kp_pkg contents:
//   - state encoding (IDLE/DEBOUNCE/HELD);
//   - KEYMAP constant (16 x 4-bit, index {row,col});
//   - NONE/SINGLE/MULTI result encoding.
//  Sub-module kp_row_sync: 4-bit 2-flop synchronizer, reset to 4'b1111.
//  Scan counter, frame evaluation and FSM stay in keypad_scanner.
// TESTING  (COL_TICKS=4, DEBOUNCE_FRAMES=3, frame=16 cycles; bench models the matrix from key_col)
//  1 Reset: rst=1 for 3 cycles -> key_col=1110, key_code=0, key_valid=0, key_held=0; key_col steps 1101 after 4 cycles.
//  2 Hold '5' (r1,c1) 20 frames -> exactly one key_valid, key_code=5, key_is_digit=1; key_held stays 1 until 3 frames after release.
//  3 Bounce: '#'(F) toggled every 8 cycles for 40 cycles, then stable -> exactly one pulse, key_code=15, key_is_digit=0.
//  4 Hold '1' and '2' together 10 frames -> no pulse; release '2' -> one pulse with key_code=1.
//  5 Hold '0', drop it for 1 frame, re-press -> no second pulse; full release >=3 frames then re-press -> second pulse, key_code=0.
//  6 rst pulsed during DEBOUNCE (frame 2 of '9') -> no pulse, key_held=0, key_col=1110 next cycle.

Source files
------------

// File: rtl/kp_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
//
// Purpose:
//   Holds the debounce FSM state encoding, the per-frame scan result
//   encoding and the physical key map of the board keypad. The package
//   also provides a lookup helper that turns a row/column position into
//   its key code.
//
// Contents:
//   kp_state_t   - ST_IDLE / ST_DEBOUNCE / ST_HELD
//   frame_res_t  - RES_NONE / RES_SINGLE / RES_MULTI
//   KEYMAP       - 16 x 4-bit codes, nibble index {row,col}
//   key_lookup() - returns the code printed on the key at (row, col)

package kp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } kp_state_t;

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } frame_res_t;

  // Keypad layout, nibble n holds the code of the key at {row,col} = n:
  //   r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: E 0 F D
  // Listed here from nibble 15 down to nibble 0.
  localparam logic [63:0] KEYMAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [3:0] key_lookup(input logic [1:0] row,
                                            input logic [1:0] col);
    logic [5:0] base;
    base = {row, col, 2'b00};
    return KEYMAP[base +: 4];
  endfunction

endpackage

// File: rtl/kp_row_sync.sv
// Two-flop synchronizer for the keypad row lines.
//
// Purpose:
//   The row inputs come straight from the keypad pins and change at any
//   time relative to clk. Two back-to-back flops give the first stage a
//   full cycle to resolve before the scanner samples the value.
//   Both stages reset to 4'b1111, i.e. "no row pulled low".
//
// Ports:
//   clk       in   1  system clock
//   rst       in   1  synchronous active-high reset
//   row_async in   4  raw active-low row lines
//   row_sync  out  4  synchronized active-low row lines

module kp_row_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_async,
  output logic [3:0] row_sync
);

  logic [3:0] row_meta;

  // Two-stage shift; the first stage may go metastable and is never
  // used by anything except the second stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta <= 4'b1111;
      row_sync <= 4'b1111;
    end else begin
      row_meta <= row_async;
      row_sync <= row_meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with frame-based debouncing.
//
// Purpose:
//   Drives one column low at a time, samples the synchronized rows at the
//   end of each column slot and classifies every full scan frame as no
//   key, exactly one key, or several keys. A three-state FSM accepts a
//   key once it has been the only key seen for DEBOUNCE_FRAMES frames in a
//   row, emits a single key_valid pulse, and then waits for
//   DEBOUNCE_FRAMES empty frames before it will accept another press.
//
// Ports:
//   clk          in   1  system clock (1 kHz)
//   rst          in   1  synchronous active-high reset
//   key_row      in   4  active-low row lines, asynchronous to clk
//   key_col      out  4  active-low one-hot column drive
//   key_code     out  4  code of the last accepted key, held until the next
//   key_valid    out  1  one-cycle pulse when a new press is accepted
//   key_held     out  1  high from acceptance until the release is debounced
//   key_is_digit out  1  key_code <= 9, registered alongside key_code

module keypad_scanner
  import kp_pkg::*;
#(
  parameter int COL_TICKS       = 4,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       key_is_digit
);

  localparam int TICK_W = (COL_TICKS > 1) ? $clog2(COL_TICKS) : 1;
  localparam int CNT_W  = (DEBOUNCE_FRAMES > 0) ? $clog2(DEBOUNCE_FRAMES + 1) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(COL_TICKS - 1);
  localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  logic [3:0]        row_sync;
  logic [TICK_W-1:0] tick;
  logic [1:0]        col_idx;
  logic              col_last;
  logic              frame_end;

  logic [3:0]        col_hits;
  logic [1:0]        col_pop;
  logic [3:0]        col_code;

  // Running frame accumulators; hit count saturates at 2 since anything
  // above one key is simply "multi".
  logic [1:0]        frame_hits;
  logic [3:0]        frame_code;
  logic [1:0]        sum_hits;
  logic [3:0]        sum_code;
  frame_res_t        frame_res;

  kp_state_t         state, state_next;
  logic [3:0]        cand, cand_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [CNT_W-1:0]  rel_cnt, rel_cnt_next;
  logic [3:0]        code_next;
  logic              digit_next;
  logic              valid_next;
  logic              held_next;

  kp_row_sync u_row_sync (
    .clk       (clk),
    .rst       (rst),
    .row_async (key_row),
    .row_sync  (row_sync)
  );

  assign key_col   = ~(4'b0001 << col_idx);
  assign col_last  = (tick == TICK_LAST);
  assign frame_end = col_last && (col_idx == 2'd3);
  assign col_hits  = ~row_sync;

  // Classify the rows seen on the current column: how many are pressed
  // (saturating at 2) and, if any, the code of the first pressed one.
  always_comb begin
    col_pop  = 2'd0;
    col_code = 4'd0;
    for (int r = 0; r < 4; r++) begin
      if (col_hits[r]) begin
        if (col_pop == 2'd0) begin
          col_code = key_lookup(2'(r), col_idx);
        end
        col_pop = (col_pop == 2'd0) ? 2'd1 : 2'd2;
      end
    end
  end

  // Merge this column into what the frame has seen so far. The code is
  // only meaningful when the merged count is exactly one, so whichever
  // side contributed the single hit supplies it.
  always_comb begin
    if (frame_hits == 2'd0) begin
      sum_hits = col_pop;
    end else if (col_pop == 2'd0) begin
      sum_hits = frame_hits;
    end else begin
      sum_hits = 2'd2;
    end
    sum_code = (frame_hits != 2'd0) ? frame_code : col_code;

    case (sum_hits)
      2'd0:    frame_res = RES_NONE;
      2'd1:    frame_res = RES_SINGLE;
      default: frame_res = RES_MULTI;
    endcase
  end

  // Column scan timing and per-frame accumulation. Accumulators clear at
  // the frame end because the merged result is consumed by the FSM on
  // that same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick       <= '0;
      col_idx    <= 2'd0;
      frame_hits <= 2'd0;
      frame_code <= 4'd0;
    end else if (col_last) begin
      tick    <= '0;
      col_idx <= col_idx + 2'd1;
      if (frame_end) begin
        frame_hits <= 2'd0;
        frame_code <= 4'd0;
      end else begin
        frame_hits <= sum_hits;
        frame_code <= sum_code;
      end
    end else begin
      tick <= tick + TICK_W'(1);
    end
  end

  // Debounce FSM state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cand         <= 4'd0;
      cnt          <= '0;
      rel_cnt      <= '0;
      key_code     <= 4'd0;
      key_is_digit <= 1'b0;
      key_valid    <= 1'b0;
      key_held     <= 1'b0;
    end else begin
      state        <= state_next;
      cand         <= cand_next;
      cnt          <= cnt_next;
      rel_cnt      <= rel_cnt_next;
      key_code     <= code_next;
      key_is_digit <= digit_next;
      key_valid    <= valid_next;
      key_held     <= held_next;
    end
  end

  // Debounce FSM next-state logic. Decisions are only taken at frame end;
  // at every other cycle everything holds and key_valid falls back low.
  always_comb begin
    state_next   = state;
    cand_next    = cand;
    cnt_next     = cnt;
    rel_cnt_next = rel_cnt;
    code_next    = key_code;
    digit_next   = key_is_digit;
    valid_next   = 1'b0;
    held_next    = key_held;

    if (frame_end) begin
      case (state)
        ST_IDLE: begin
          if (frame_res == RES_SINGLE) begin
            cand_next  = sum_code;
            cnt_next   = CNT_ONE;
            state_next = ST_DEBOUNCE;
          end
        end

        ST_DEBOUNCE: begin
          if (frame_res == RES_SINGLE && sum_code == cand) begin
            if (cnt + CNT_ONE == CNT_DONE) begin
              code_next    = cand;
              digit_next   = (cand <= 4'd9);
              valid_next   = 1'b1;
              held_next    = 1'b1;
              cnt_next     = '0;
              rel_cnt_next = '0;
              state_next   = ST_HELD;
            end else begin
              cnt_next = cnt + CNT_ONE;
            end
          end else if (frame_res == RES_SINGLE) begin
            cand_next = sum_code;
            cnt_next  = CNT_ONE;
          end else begin
            cnt_next   = '0;
            state_next = ST_IDLE;
          end
        end

        ST_HELD: begin
          // Any frame that still shows a key, even a different one or
          // several, restarts the release count.
          if (frame_res == RES_NONE) begin
            if (rel_cnt + CNT_ONE == CNT_DONE) begin
              held_next    = 1'b0;
              rel_cnt_next = '0;
              state_next   = ST_IDLE;
            end else begin
              rel_cnt_next = rel_cnt + CNT_ONE;
            end
          end else begin
            rel_cnt_next = '0;
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed testbench for keypad_scanner.
//
// Purpose:
//   Models the physical key matrix from key_col and a 16-bit "pressed"
//   mask (bit {row,col}), walks through reset, single presses, bounce,
//   multi-key, release glitch and mid-debounce reset scenarios, and
//   compares the outputs against hand-derived values.

module tb_keypad_scanner;

  localparam logic [15:0] K_1    = 16'h0001;
  localparam logic [15:0] K_2    = 16'h0002;
  localparam logic [15:0] K_5    = 16'h0020;
  localparam logic [15:0] K_9    = 16'h0400;
  localparam logic [15:0] K_0    = 16'h2000;
  localparam logic [15:0] K_F    = 16'h4000;
  localparam logic [15:0] K_NONE = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        key_is_digit;
  logic [15:0] pressed;

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  keypad_scanner #(
    .COL_TICKS       (4),
    .DEBOUNCE_FRAMES (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_row      (key_row),
    .key_col      (key_col),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .key_held     (key_held),
    .key_is_digit (key_is_digit)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row to its column; a row reads low when any
  // pressed key on it sits in the column currently driven low.
  always_comb begin
    key_row = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4 + c] && !key_col[c]) begin
          key_row[r] = 1'b0;
        end
      end
    end
  end

  // Count every cycle key_valid is high, so a stretched pulse shows up as
  // an extra press.
  always begin
    @(posedge clk);
    #1;
    if (key_valid === 1'b1) begin
      pulses++;
    end
  end

  task automatic applyStimulus(input logic [15:0] keys, input int cycles);
    pressed = keys;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    rst     = 1'b1;
    pressed = K_NONE;

    // Reset state and first column step.
    repeat (3) @(negedge clk);
    checkOutput("rst_key_col",   32'(key_col),      32'hE);
    checkOutput("rst_key_code",  32'(key_code),     32'd0);
    checkOutput("rst_key_valid", 32'(key_valid),    32'd0);
    checkOutput("rst_key_held",  32'(key_held),     32'd0);
    checkOutput("rst_is_digit",  32'(key_is_digit), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("col0_after3",   32'(key_col),      32'hE);
    @(negedge clk);
    checkOutput("col1_after4",   32'(key_col),      32'hD);

    // Long hold of '5', then release.
    $display("[TB] hold 5");
    applyStimulus(K_5, 320);
    checkOutput("k5_pulses",  32'(pulses),       32'd1);
    checkOutput("k5_code",    32'(key_code),     32'd5);
    checkOutput("k5_digit",   32'(key_is_digit), 32'd1);
    checkOutput("k5_held",    32'(key_held),     32'd1);
    applyStimulus(K_NONE, 32);
    checkOutput("k5_held_rel2", 32'(key_held),   32'd1);
    applyStimulus(K_NONE, 48);
    checkOutput("k5_held_rel5", 32'(key_held),   32'd0);
    checkOutput("k5_code_kept", 32'(key_code),   32'd5);
    checkOutput("k5_pulses_end", 32'(pulses),    32'd1);

    // Bouncing 'F' then stable.
    $display("[TB] bounce F");
    for (int i = 0; i < 5; i++) begin
      applyStimulus((i % 2 == 0) ? K_F : K_NONE, 8);
    end
    applyStimulus(K_F, 128);
    checkOutput("kf_pulses", 32'(pulses),       32'd2);
    checkOutput("kf_code",   32'(key_code),     32'd15);
    checkOutput("kf_digit",  32'(key_is_digit), 32'd0);
    checkOutput("kf_held",   32'(key_held),     32'd1);
    applyStimulus(K_NONE, 80);
    checkOutput("kf_released", 32'(key_held),   32'd0);

    // '1' and '2' together, then release '2'.
    $display("[TB] multi key");
    applyStimulus(K_1 | K_2, 160);
    checkOutput("multi_pulses", 32'(pulses),    32'd2);
    checkOutput("multi_held",   32'(key_held),  32'd0);
    applyStimulus(K_1, 96);
    checkOutput("k1_pulses", 32'(pulses),       32'd3);
    checkOutput("k1_code",   32'(key_code),     32'd1);
    checkOutput("k1_digit",  32'(key_is_digit), 32'd1);
    applyStimulus(K_NONE, 80);
    checkOutput("k1_released", 32'(key_held),   32'd0);

    // '0' with a one-frame release glitch, then full release and re-press.
    $display("[TB] release glitch 0");
    applyStimulus(K_0, 96);
    checkOutput("k0_pulses", 32'(pulses),       32'd4);
    checkOutput("k0_code",   32'(key_code),     32'd0);
    applyStimulus(K_NONE, 16);
    applyStimulus(K_0, 96);
    checkOutput("k0_glitch_pulses", 32'(pulses),   32'd4);
    checkOutput("k0_glitch_held",   32'(key_held), 32'd1);
    applyStimulus(K_NONE, 80);
    checkOutput("k0_released", 32'(key_held),   32'd0);
    applyStimulus(K_0, 96);
    checkOutput("k0_second_pulses", 32'(pulses),       32'd5);
    checkOutput("k0_second_code",   32'(key_code),     32'd0);
    checkOutput("k0_second_digit",  32'(key_is_digit), 32'd1);
    applyStimulus(K_NONE, 80);

    // Reset in the middle of debouncing '9', then exact-latency re-press.
    $display("[TB] reset during debounce 9");
    applyStimulus(K_9, 24);
    checkOutput("k9_pre_rst_pulses", 32'(pulses), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("k9_rst_col",   32'(key_col),   32'hE);
    checkOutput("k9_rst_held",  32'(key_held),  32'd0);
    checkOutput("k9_rst_valid", 32'(key_valid), 32'd0);
    rst = 1'b0;
    repeat (47) @(negedge clk);
    checkOutput("k9_no_early_valid", 32'(key_valid), 32'd0);
    checkOutput("k9_no_early_pulse", 32'(pulses),    32'd5);
    @(negedge clk);
    checkOutput("k9_valid",  32'(key_valid),    32'd1);
    checkOutput("k9_code",   32'(key_code),     32'd9);
    checkOutput("k9_digit",  32'(key_is_digit), 32'd1);
    @(negedge clk);
    checkOutput("k9_valid_drop", 32'(key_valid), 32'd0);
    checkOutput("k9_pulses",     32'(pulses),    32'd6);
    applyStimulus(K_NONE, 80);
    checkOutput("k9_released",   32'(key_held),  32'd0);
    checkOutput("final_pulses",  32'(pulses),    32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
